// File: rtl/shift_round_saturate.sv
// Two-stage requantiser: round-half-up drop of DROP_BITS LSBs, then signed
// saturation to OUTPUT_DATA_WIDTH with per-sample, sticky and counted saturation.
module shift_round_saturate #(
    parameter     BLOCK_NAME        = "shift_round_saturate",
    parameter int X                 = 0,
    parameter int Y                 = 0,
    parameter int DX                = 0,
    parameter int DY                = 0,
    parameter     ARCHITECTURE      = "BEHAVIORAL",
    parameter int INPUT_DATA_WIDTH  = 16,
    parameter int DROP_BITS         = 4,
    parameter int OUTPUT_DATA_WIDTH = 8,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUT_DATA_WIDTH-1:0]  data_in,
    input  logic                         valid_in,
    input  logic                         clr_stats,
    output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
    output logic                         valid_out,
    output logic                         sat_out,
    output logic                         sat_flag,
    output logic [COUNT_WIDTH-1:0]       sat_count
);

    localparam int IW = INPUT_DATA_WIDTH;
    localparam int OW = OUTPUT_DATA_WIDTH;
    localparam int CW = COUNT_WIDTH;
    localparam int RW = IW - DROP_BITS + 1;

    // Diagram-only parameters; they carry no logic.
    logic unused_params;
    assign unused_params = ((X + Y + DX + DY) != 0) || (BLOCK_NAME == "");

    // valid_in qualifies data_in in the same cycle; there is no ready, every
    // valid sample yields one valid_out two registers later.
    if (ARCHITECTURE == "BEHAVIORAL") begin : g_behav
        logic [RW-1:0] r_d, r_q;
        logic          v1_q;
        logic [OW-1:0] y_d, y_q;
        logic          s_d, s_q, v2_q;
        logic          flag_d, flag_q;
        logic [CW-1:0] cnt_d, cnt_q;
        logic [RW-OW:0] hi;
        logic          ev;

        if (DROP_BITS == 0) begin : g_nodrop
            assign r_d = {data_in[IW-1], data_in};
        end else begin : g_round
            localparam logic [IW:0] HALF = (IW+1)'(1) << (DROP_BITS - 1);
            logic [IW:0] sum;
            assign sum = {data_in[IW-1], data_in} + HALF;
            assign r_d = RW'(sum >> DROP_BITS);
        end

        // In range exactly when every bit from the output sign upward agrees.
        assign hi = r_q[RW-1:OW-1];

        always_comb begin
            y_d = r_q[OW-1:0];
            s_d = 1'b0;
            if (!((&hi) || (~|hi))) begin
                s_d = 1'b1;
                y_d = r_q[RW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
            end
        end

        assign ev = v1_q & s_d;

        always_comb begin
            flag_d = flag_q | ev;
            cnt_d  = cnt_q;
            if (ev && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
            // A clear never swallows an event landing on the same edge.
            if (clr_stats) begin
                flag_d = ev;
                cnt_d  = {{(CW-1){1'b0}}, ev};
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q    <= '0;
                v1_q   <= 1'b0;
                y_q    <= '0;
                s_q    <= 1'b0;
                v2_q   <= 1'b0;
                flag_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                r_q    <= r_d;
                v1_q   <= valid_in;
                y_q    <= y_d;
                s_q    <= ev;
                v2_q   <= v1_q;
                flag_q <= flag_d;
                cnt_q  <= cnt_d;
            end
        end

        assign data_out  = y_q;
        assign valid_out = v2_q;
        assign sat_out   = s_q;
        assign sat_flag  = flag_q;
        assign sat_count = cnt_q;
    end else begin : g_placeholder
        assign data_out  = '0;
        assign valid_out = 1'b0;
        assign sat_out   = 1'b0;
        assign sat_flag  = 1'b0;
        assign sat_count = '0;
    end

endmodule
